alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised multi-cycle integer ALU; successor to the fixed 32-bit ALU.
- Single-cycle ops: add, sub, and, or, xor, set-less-than.
- Iterative unsigned DIV and MOD use a restoring divider, one quotient bit per clock.
- Start/Busy/We handshake so a datapath controller can issue ops and wait for completion. It sits in the execute stage beside the register file write-back.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  operand A / dividend.
- B  in  WIDTH  operand B / divisor.
- ALUOp  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 DIV (unsigned quotient), 7 MOD (unsigned remainder).
- Busy  out  1  high while a division is in progress; Start is ignored while high.
- Z  out  1  registered; set when Result == 0.
- V  out  1  registered; signed overflow (ADD/SUB) or divide-by-zero (DIV/MOD).
- C  out  1  registered; carry-out bit WIDTH of the add/sub.
- Result  out  WIDTH  registered result; holds until the next completion.
- We  out  1  one-cycle completion pulse, write-enable for the register file.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; Result, Z, V, C, We, Busy all 0; counter and divider registers cleared. An in-flight division is discarded with no We pulse.
- The block latches A, B and ALUOp on the accepting edge. Later input changes do not affect the op in flight.
- FSM states: IDLE, DIV.
- IDLE, Start=1, ALUOp 0-5: result computed and registered at the same edge. We=1 for exactly the following cycle; latency 1 edge; state stays IDLE.
- IDLE, Start=1, ALUOp 6/7, B==0: completes at the same edge with latency 1.
  - DIV: Result = all ones, V=1.
  - MOD: Result = A, V=1.
  - C=0 in both cases.
- IDLE, Start=1, ALUOp 6/7, B!=0:
  - Go to DIV; Busy=1 from the next cycle.
  - Load remainder=0, quotient=A, divisor=B, counter=0.
- DIV state, each edge:
  - Shift {rem,quo} left by 1.
  - If the shifted remainder >= divisor: subtract divisor and set quotient LSB=1.
  - Increment counter.
- When the iteration with counter==WIDTH-1 executes:
  - Register Result (quotient for DIV, remainder for MOD), V=0, C=0.
  - Pulse We; return to IDLE; Busy=0.
  - Total latency from the accepting edge to Result valid is WIDTH+1 edges. We is high during the cycle after edge WIDTH+1.
- ADD: {C,Result} = A+B. V = (A[msb]==B[msb]) && (Result[msb]!=A[msb]).
- SUB: {C,Result} = A + ~B + 1, so C=1 iff A>=B unsigned. V = (A[msb]!=B[msb]) && (Result[msb]!=A[msb]).
- AND/OR/XOR: C=0, V=0.
- SLT: Result = 1 if signed A < signed B, else 0 (zero-extended to WIDTH). C=0, V=0.
- Z is always updated together with Result, on every completion.
- Z, V, C and Result change only on a completion edge; otherwise they hold.
- We is low in every cycle not immediately following a completion edge.
- Start=1 while Busy=1: ignored entirely, with no queueing.
- Start=1 in the cycle where We=1 (IDLE): accepted normally, allowing back-to-back single-cycle ops at one per clock.
- Invalid states are unreachable; the default branch returns to IDLE.

Test Plan:
- WIDTH=32. Reset low 2 cycles, release; Start with ALUOp=7, A=16, B=5 -> Busy high 32 cycles. We pulses once, 33 edges after acceptance, with Result=1, Z=0, V=0, C=0.
- ADD A=0xFFFFFFFF, B=1 -> next cycle We=1, Result=0, Z=1, C=1, V=0. ADD A=0x7FFFFFFF, B=1 -> Result=0x80000000, V=1, C=0.
- SUB A=3, B=5 -> Result=0xFFFFFFFE, C=0, V=0. SLT A=0xFFFFFFFF (-1), B=1 -> Result=1. Issue both back-to-back on consecutive cycles -> two consecutive We pulses.
- DIV A=100, B=0 -> latency 1, Result=0xFFFFFFFF, V=1. MOD A=100, B=0 -> Result=100, V=1, Busy never asserts.
- DIV A=100, B=7; after 10 cycles pulse Start with ADD 1+1 -> ADD ignored. Single We with Result=14, Z=0; Result holds 14 afterwards.
- DIV A=0xFFFFFFFF, B=3; assert Reset low at cycle 15 -> Busy=0, Result=0, no We; after release, MOD 16,5 completes correctly with Result=1.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU: single-cycle arithmetic/logic ops plus an iterative
// unsigned restoring divider (one quotient bit per clock) behind a Start/Busy/We handshake.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic             Busy,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic [WIDTH-1:0] Result,
    output logic             We
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_MOD = 3'd7;

    typedef enum logic {IDLE, DIV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mod_q, mod_d;
    logic [WIDTH-1:0] res_d;
    logic             z_d, v_d, c_d, we_d;

    logic             sub_op, slt;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh, diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            mod_q   <= 1'b0;
            Result  <= '0;
            Z       <= 1'b0;
            V       <= 1'b0;
            C       <= 1'b0;
            We      <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            mod_q   <= mod_d;
            Result  <= res_d;
            Z       <= z_d;
            V       <= v_d;
            C       <= c_d;
            We      <= we_d;
        end
    end

    assign Busy = (state_q == DIV);

    // SUB reuses the adder as A + ~B + 1, so C doubles as the unsigned A >= B flag.
    assign sub_op = (ALUOp == OP_SUB);
    assign b_op   = sub_op ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_op};
    assign slt    = ($signed(A) < $signed(B));

    // Shifted remainder needs one extra bit; the borrow of the trial subtract is the compare.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign ge     = ~diff[WIDTH];
    assign rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        mod_d   = mod_q;
        res_d   = Result;
        z_d     = Z;
        v_d     = V;
        c_d     = C;
        we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    we_d = 1'b1;
                    v_d  = 1'b0;
                    c_d  = 1'b0;
                    case (ALUOp)
                        OP_ADD, OP_SUB: begin
                            res_d = sum[WIDTH-1:0];
                            c_d   = sum[WIDTH];
                            v_d   = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
                        end
                        OP_AND: res_d = A & B;
                        OP_OR:  res_d = A | B;
                        OP_XOR: res_d = A ^ B;
                        OP_SLT: res_d = {{(WIDTH-1){1'b0}}, slt};
                        OP_DIV, OP_MOD: begin
                            if (B == '0) begin
                                res_d = (ALUOp == OP_MOD) ? A : '1;
                                v_d   = 1'b1;
                            end else begin
                                we_d    = 1'b0;
                                res_d   = Result;
                                v_d     = V;
                                c_d     = C;
                                state_d = DIV;
                                rem_d   = '0;
                                quo_d   = A;
                                dvs_d   = B;
                                cnt_d   = '0;
                                mod_d   = (ALUOp == OP_MOD);
                            end
                        end
                        default: res_d = Result;
                    endcase
                end
            end
            DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_d   = mod_q ? rem_nx : quo_nx;
                    v_d     = 1'b0;
                    c_d     = 1'b0;
                    we_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (we_d) z_d = (res_d == '0);
    end

endmodule
